// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline control block:
// run-mode state encoding, forwarding-select codes and the HALT opcode.
package mips_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_RUN  = 3'd2,
      ST_STEP = 3'd3,
      ST_HALT = 3'd4
   } state_t;

   localparam logic [1:0] FWD_REG   = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b10;
   localparam logic [1:0] FWD_MEMWB = 2'b01;

   localparam logic [5:0] OP_HALT = 6'b111111;

endpackage

// File: rtl/mips_pipe_ctrl_if.sv
// Bundle between the pipeline control block and the datapath/debug side:
// program-load port, run commands, hazard inputs and the resulting enables.
interface mips_pipe_ctrl_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int REG_BITS   = 5,
   parameter int CNT_WIDTH  = 32
);

   logic                  load_start;
   logic                  load_valid;
   logic [DATA_WIDTH-1:0] load_data;
   logic                  load_done;
   logic                  run;
   logic                  step;
   logic                  halt_wb;
   logic                  branch_taken;
   logic                  idex_memread;
   logic [REG_BITS-1:0]   idex_rs;
   logic [REG_BITS-1:0]   idex_rt;
   logic [REG_BITS-1:0]   ifid_rs;
   logic [REG_BITS-1:0]   ifid_rt;
   logic                  exmem_regwrite;
   logic                  memwb_regwrite;
   logic [REG_BITS-1:0]   exmem_rd;
   logic [REG_BITS-1:0]   memwb_rd;

   logic                  pipe_en;
   logic                  pc_en;
   logic                  ifid_en;
   logic                  flush_ifid;
   logic                  flush_idex;
   logic [1:0]            fwd_a;
   logic [1:0]            fwd_b;
   logic                  imem_we;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic [DATA_WIDTH-1:0] imem_wdata;
   logic                  load_full;
   logic                  pipe_clear;
   logic [2:0]            state;
   logic [CNT_WIDTH-1:0]  cycle_count;

   modport master (
      output load_start, load_valid, load_data, load_done, run, step, halt_wb,
             branch_taken, idex_memread, idex_rs, idex_rt, ifid_rs, ifid_rt,
             exmem_regwrite, memwb_regwrite, exmem_rd, memwb_rd,
      input  pipe_en, pc_en, ifid_en, flush_ifid, flush_idex, fwd_a, fwd_b,
             imem_we, imem_addr, imem_wdata, load_full, pipe_clear, state,
             cycle_count
   );

   modport slave (
      input  load_start, load_valid, load_data, load_done, run, step, halt_wb,
             branch_taken, idex_memread, idex_rs, idex_rt, ifid_rs, ifid_rt,
             exmem_regwrite, memwb_regwrite, exmem_rd, memwb_rd,
      output pipe_en, pc_en, ifid_en, flush_ifid, flush_idex, fwd_a, fwd_b,
             imem_we, imem_addr, imem_wdata, load_full, pipe_clear, state,
             cycle_count
   );

endinterface

// File: rtl/mips_hazard_fwd.sv
// Combinational load-use stall, branch flush and EX operand forwarding.
// Stall/flush outputs follow pipe_en; forwarding only follows fwd_en.
module mips_hazard_fwd
   import mips_pkg::*;
#(
   parameter int REG_BITS = 5
) (
   input  logic                pipe_en,
   input  logic                fwd_en,
   input  logic                branch_taken,
   input  logic                idex_memread,
   input  logic [REG_BITS-1:0] idex_rs,
   input  logic [REG_BITS-1:0] idex_rt,
   input  logic [REG_BITS-1:0] ifid_rs,
   input  logic [REG_BITS-1:0] ifid_rt,
   input  logic                exmem_regwrite,
   input  logic [REG_BITS-1:0] exmem_rd,
   input  logic                memwb_regwrite,
   input  logic [REG_BITS-1:0] memwb_rd,
   output logic                pc_en,
   output logic                ifid_en,
   output logic                flush_ifid,
   output logic                flush_idex,
   output logic [1:0]          fwd_a,
   output logic [1:0]          fwd_b
);

   logic stall;

   // EX/MEM holds the younger result, so it must win over MEM/WB.
   function automatic logic [1:0] fwd_sel(
      input logic [REG_BITS-1:0] src,
      input logic                em_we,
      input logic [REG_BITS-1:0] em_rd,
      input logic                mw_we,
      input logic [REG_BITS-1:0] mw_rd
   );
      fwd_sel = FWD_REG;
      if (em_we && (em_rd != '0) && (em_rd == src))
         fwd_sel = FWD_EXMEM;
      else if (mw_we && (mw_rd != '0) && (mw_rd == src))
         fwd_sel = FWD_MEMWB;
   endfunction

   assign stall = idex_memread && (idex_rt != '0) &&
                  ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

   assign pc_en      = pipe_en & ~stall;
   assign ifid_en    = pipe_en & ~stall;
   assign flush_idex = pipe_en & stall;
   // A stalled branch keeps IF/ID intact and resolves again next cycle.
   assign flush_ifid = pipe_en & branch_taken & ~stall;

   assign fwd_a = fwd_en ? fwd_sel(idex_rs, exmem_regwrite, exmem_rd,
                                   memwb_regwrite, memwb_rd) : FWD_REG;
   assign fwd_b = fwd_en ? fwd_sel(idex_rt, exmem_regwrite, exmem_rd,
                                   memwb_regwrite, memwb_rd) : FWD_REG;

endmodule

// File: rtl/mips_pipe_ctrl.sv
// Central control for the 5-stage MIPS pipeline: run-mode FSM, instruction
// memory load port, cycle counter, plus the hazard/forwarding sub-block.
module mips_pipe_ctrl
   import mips_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int REG_BITS   = 5,
   parameter int CNT_WIDTH  = 32
) (
   input  logic            i_clock,
   input  logic            i_reset,
   mips_pipe_ctrl_if.slave bus
);

   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

   state_t                state;
   state_t                state_next;
   logic                  pipe_en;
   logic                  load_entry;
   logic                  imem_we;
   logic                  load_full;
   logic                  pipe_clear;
   logic [ADDR_WIDTH-1:0] addr;
   logic [CNT_WIDTH-1:0]  count;
   logic [DATA_WIDTH-1:0] wdata;

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) state <= ST_IDLE;
      else          state <= state_next;
   end

   // NOTE: defaults first, so no path through the case can infer a latch.
   always_comb begin
      state_next = state;
      pipe_en    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.load_start)  state_next = ST_LOAD;
            else if (bus.run)    state_next = ST_RUN;
            else if (bus.step)   state_next = ST_STEP;
         end
         ST_LOAD: begin
            if (bus.load_done) state_next = ST_IDLE;
         end
         ST_RUN: begin
            pipe_en = 1'b1;
            if (bus.halt_wb) state_next = ST_HALT;
         end
         ST_STEP: begin
            pipe_en    = 1'b1;
            state_next = bus.halt_wb ? ST_HALT : ST_IDLE;
         end
         ST_HALT: begin
            if (bus.load_start) state_next = ST_LOAD;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign load_entry = (state_next == ST_LOAD) && (state != ST_LOAD);
   assign imem_we    = (state == ST_LOAD) && bus.load_valid && !load_full;
   assign wdata      = imem_we ? bus.load_data : '0;

   // Entry into LOAD restarts the image and the cycle count; the clear pulse
   // lands on the first LOAD cycle.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         addr       <= '0;
         count      <= '0;
         load_full  <= 1'b0;
         pipe_clear <= 1'b0;
      end else begin
         pipe_clear <= load_entry;
         if (load_entry) begin
            addr      <= '0;
            count     <= '0;
            load_full <= 1'b0;
         end else begin
            if (imem_we) begin
               if (addr == ADDR_LAST) load_full <= 1'b1;
               else                   addr      <= addr + 1'b1;
            end
            if (pipe_en) count <= count + 1'b1;
         end
      end
   end

   assign bus.pipe_en     = pipe_en;
   assign bus.imem_we     = imem_we;
   assign bus.imem_addr   = addr;
   assign bus.imem_wdata  = wdata;
   assign bus.load_full   = load_full;
   assign bus.pipe_clear  = pipe_clear;
   assign bus.state       = state;
   assign bus.cycle_count = count;

   // Reset also forces forwarding to the register file, since it is not
   // otherwise gated by the run mode.
   mips_hazard_fwd #(
      .REG_BITS(REG_BITS)
   ) u_hazard_fwd (
      .pipe_en        (pipe_en),
      .fwd_en         (i_reset),
      .branch_taken   (bus.branch_taken),
      .idex_memread   (bus.idex_memread),
      .idex_rs        (bus.idex_rs),
      .idex_rt        (bus.idex_rt),
      .ifid_rs        (bus.ifid_rs),
      .ifid_rt        (bus.ifid_rt),
      .exmem_regwrite (bus.exmem_regwrite),
      .exmem_rd       (bus.exmem_rd),
      .memwb_regwrite (bus.memwb_regwrite),
      .memwb_rd       (bus.memwb_rd),
      .pc_en          (bus.pc_en),
      .ifid_en        (bus.ifid_en),
      .flush_ifid     (bus.flush_ifid),
      .flush_idex     (bus.flush_idex),
      .fwd_a          (bus.fwd_a),
      .fwd_b          (bus.fwd_b)
   );

endmodule

// File: tb/tb_mips_pipe_ctrl.sv
// Self-checking bench for mips_pipe_ctrl: a behavioural run-mode model is
// compared every negedge, and directed vectors pin hand-computed values.
module tb_mips_pipe_ctrl;

   localparam int DW    = 32;
   localparam int AW    = 2;
   localparam int RB    = 5;
   localparam int CW    = 32;
   localparam int DEPTH = 4;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LOAD = 3'd1;
   localparam logic [2:0] S_RUN  = 3'd2;
   localparam logic [2:0] S_STEP = 3'd3;
   localparam logic [2:0] S_HALT = 3'd4;

   logic clk;
   logic rst_n;
   int   n_checks = 0;
   int   n_errors = 0;

   mips_pipe_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_BITS(RB),
                       .CNT_WIDTH(CW)) bus ();

   mips_pipe_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_BITS(RB),
                    .CNT_WIDTH(CW)) dut (
      .i_clock (clk),
      .i_reset (rst_n),
      .bus     (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [2:0]    m_mode;
   logic [CW-1:0] m_count;
   int            m_addr;
   bit            m_full;
   bit            m_clear;

   function automatic logic [1:0] exp_fwd(input logic [RB-1:0] src,
                                          input logic ew, input logic [RB-1:0] erd,
                                          input logic mw, input logic [RB-1:0] mrd);
      if (src == 0)               return 2'b00;
      if (ew && (erd == src))     return 2'b10;
      if (mw && (mrd == src))     return 2'b01;
      return 2'b00;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode  <= S_IDLE;
         m_count <= '0;
         m_addr  <= 0;
         m_full  <= 1'b0;
         m_clear <= 1'b0;
      end else begin
         m_clear <= 1'b0;
         if ((m_mode == S_IDLE || m_mode == S_HALT) && bus.load_start) begin
            m_mode  <= S_LOAD;
            m_addr  <= 0;
            m_count <= '0;
            m_full  <= 1'b0;
            m_clear <= 1'b1;
         end else if (m_mode == S_IDLE) begin
            if (bus.run)       m_mode <= S_RUN;
            else if (bus.step) m_mode <= S_STEP;
         end else if (m_mode == S_LOAD) begin
            if (bus.load_valid && !m_full) begin
               if (m_addr == DEPTH - 1) m_full <= 1'b1;
               else                     m_addr <= m_addr + 1;
            end
            if (bus.load_done) m_mode <= S_IDLE;
         end else if (m_mode == S_RUN || m_mode == S_STEP) begin
            m_count <= m_count + 1;
            if (bus.halt_wb)           m_mode <= S_HALT;
            else if (m_mode == S_STEP) m_mode <= S_IDLE;
         end
      end
   end

   always @(negedge clk) begin
      logic       en, stall, e_we;
      logic [1:0] e_fa, e_fb;
      en    = (m_mode == S_RUN) || (m_mode == S_STEP);
      stall = bus.idex_memread && (bus.idex_rt != 0) &&
              ((bus.idex_rt == bus.ifid_rs) || (bus.idex_rt == bus.ifid_rt));
      e_we  = (m_mode == S_LOAD) && bus.load_valid && !m_full;
      e_fa  = rst_n ? exp_fwd(bus.idex_rs, bus.exmem_regwrite, bus.exmem_rd,
                              bus.memwb_regwrite, bus.memwb_rd) : 2'b00;
      e_fb  = rst_n ? exp_fwd(bus.idex_rt, bus.exmem_regwrite, bus.exmem_rd,
                              bus.memwb_regwrite, bus.memwb_rd) : 2'b00;
      check("cmp_state",      bus.state,       m_mode);
      check("cmp_pipe_en",    bus.pipe_en,     en);
      check("cmp_pc_en",      bus.pc_en,       en && !stall);
      check("cmp_ifid_en",    bus.ifid_en,     en && !stall);
      check("cmp_flush_idex", bus.flush_idex,  en && stall);
      check("cmp_flush_ifid", bus.flush_ifid,  en && bus.branch_taken && !stall);
      check("cmp_fwd_a",      bus.fwd_a,       e_fa);
      check("cmp_fwd_b",      bus.fwd_b,       e_fb);
      check("cmp_imem_we",    bus.imem_we,     e_we);
      check("cmp_imem_addr",  bus.imem_addr,   m_addr);
      if (e_we) check("cmp_imem_wdata", bus.imem_wdata, bus.load_data);
      check("cmp_load_full",  bus.load_full,   m_full);
      check("cmp_pipe_clear", bus.pipe_clear,  m_clear);
      check("cmp_count",      bus.cycle_count, m_count);
   end

   // ---------------- directed stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_inputs();
      bus.load_start = 0; bus.load_valid = 0; bus.load_data = '0; bus.load_done = 0;
      bus.run = 0; bus.step = 0; bus.halt_wb = 0; bus.branch_taken = 0;
      bus.idex_memread = 0; bus.idex_rs = '0; bus.idex_rt = '0;
      bus.ifid_rs = '0; bus.ifid_rt = '0;
      bus.exmem_regwrite = 0; bus.memwb_regwrite = 0;
      bus.exmem_rd = '0; bus.memwb_rd = '0;
   endtask

   initial begin
      rst_n = 1'b0;
      clear_inputs();
      bus.exmem_regwrite = 1; bus.exmem_rd = 4; bus.idex_rs = 4;
      #1;
      check("rst_state", bus.state, 3'd0);
      check("rst_count", bus.cycle_count, 0);
      check("rst_fwd_a", bus.fwd_a, 2'b00);
      cyc(); cyc();
      rst_n = 1'b1;
      #1;
      check("fwd_a_after_rst", bus.fwd_a, 2'b10);
      clear_inputs();

      // short load, done arriving with the last valid word
      bus.load_start = 1; cyc(); bus.load_start = 0; #1;
      check("load_entry_state", bus.state, 3'd1);
      check("load_entry_clear", bus.pipe_clear, 1'b1);
      cyc();
      bus.load_valid = 1; bus.load_data = 32'h1111_0000; #1;
      check("short_we0", bus.imem_we, 1'b1);
      check("short_clear_gone", bus.pipe_clear, 1'b0);
      cyc();
      bus.load_data = 32'h1111_0001; bus.load_done = 1; #1;
      check("short_we1_with_done", bus.imem_we, 1'b1);
      check("short_addr1", bus.imem_addr, 2'd1);
      check("short_wdata1", bus.imem_wdata, 32'h1111_0001);
      cyc();
      clear_inputs(); #1;
      check("short_back_idle", bus.state, 3'd0);

      // single step
      bus.step = 1; cyc(); bus.step = 0; #1;
      check("step_state", bus.state, 3'd3);
      check("step_pipe_en", bus.pipe_en, 1'b1);
      check("step_count0", bus.cycle_count, 0);
      cyc(); #1;
      check("step_idle", bus.state, 3'd0);
      check("step_en_off", bus.pipe_en, 1'b0);
      check("step_count1", bus.cycle_count, 1);

      // free run with hazard vectors, then reset at count 7
      bus.run = 1; cyc(); bus.run = 0; #1;
      check("run_state", bus.state, 3'd2);
      bus.idex_memread = 1; bus.idex_rt = 3; bus.ifid_rs = 3; bus.branch_taken = 1; #1;
      check("stall_pc_en", bus.pc_en, 1'b0);
      check("stall_ifid_en", bus.ifid_en, 1'b0);
      check("stall_flush_idex", bus.flush_idex, 1'b1);
      check("stall_flush_ifid", bus.flush_ifid, 1'b0);
      cyc();
      bus.idex_rt = 0; #1;
      check("rt0_pc_en", bus.pc_en, 1'b1);
      check("rt0_flush_idex", bus.flush_idex, 1'b0);
      check("rt0_flush_ifid", bus.flush_ifid, 1'b1);
      cyc();
      bus.idex_rt = 7; bus.ifid_rs = 1; bus.ifid_rt = 7; bus.branch_taken = 0; #1;
      check("stall_rt_pc_en", bus.pc_en, 1'b0);
      check("stall_rt_flush_idex", bus.flush_idex, 1'b1);
      cyc();
      clear_inputs();
      cyc(); cyc(); cyc(); #1;
      check("run_count7", bus.cycle_count, 7);
      bus.load_valid = 1;
      rst_n = 1'b0; #1;
      check("midrun_rst_state", bus.state, 3'd0);
      check("midrun_rst_count", bus.cycle_count, 0);
      check("midrun_rst_pipe_en", bus.pipe_en, 1'b0);
      cyc(); #1;
      check("midrun_rst_edge_state", bus.state, 3'd0);
      check("midrun_rst_edge_we", bus.imem_we, 1'b0);
      rst_n = 1'b1;
      clear_inputs();
      cyc();

      // load five words into a four-word memory
      bus.load_start = 1; cyc(); bus.load_start = 0;
      for (int i = 0; i < 5; i++) begin
         bus.load_valid = 1; bus.load_data = 32'hA000_0000 + i; #1;
         check("fill_we", bus.imem_we, (i < 4) ? 1'b1 : 1'b0);
         check("fill_addr", bus.imem_addr, (i < 4) ? i : 3);
         check("fill_full", bus.load_full, (i == 4) ? 1'b1 : 1'b0);
         cyc();
      end
      bus.load_valid = 0; bus.load_done = 1; cyc(); bus.load_done = 0; #1;
      check("fill_idle", bus.state, 3'd0);
      check("fill_full_held", bus.load_full, 1'b1);

      // run, halt on the tenth enabled cycle
      bus.run = 1; cyc(); bus.run = 0;
      repeat (9) cyc();
      bus.halt_wb = 1; #1;
      check("halt_cycle_enabled", bus.pipe_en, 1'b1);
      check("halt_cycle_count9", bus.cycle_count, 9);
      cyc(); bus.halt_wb = 0; #1;
      check("halt_state", bus.state, 3'd4);
      check("halt_count10", bus.cycle_count, 10);
      check("halt_pipe_en", bus.pipe_en, 1'b0);
      bus.run = 1; cyc(); bus.run = 0; bus.step = 1; cyc(); bus.step = 0; #1;
      check("halt_ignores_run_step", bus.state, 3'd4);
      check("halt_count_held", bus.cycle_count, 10);
      bus.load_start = 1; cyc(); bus.load_start = 0; #1;
      check("reload_state", bus.state, 3'd1);
      check("reload_clear", bus.pipe_clear, 1'b1);
      check("reload_count0", bus.cycle_count, 0);
      check("reload_full0", bus.load_full, 1'b0);

      // forwarding priority, not gated by mode
      cyc();
      bus.exmem_regwrite = 1; bus.memwb_regwrite = 1;
      bus.exmem_rd = 4; bus.memwb_rd = 4; bus.idex_rs = 4; #1;
      check("fwd_exmem", bus.fwd_a, 2'b10);
      cyc();
      bus.exmem_rd = 0; #1;
      check("fwd_memwb", bus.fwd_a, 2'b01);
      cyc();
      bus.idex_rs = 0; bus.idex_rt = 4; #1;
      check("fwd_zero_src", bus.fwd_a, 2'b00);
      check("fwd_b_memwb", bus.fwd_b, 2'b01);
      cyc();
      bus.exmem_rd = 4; bus.exmem_regwrite = 0; #1;
      check("fwd_b_no_regwrite", bus.fwd_b, 2'b01);
      cyc();
      clear_inputs();
      bus.load_done = 1; cyc(); bus.load_done = 0;
      cyc(); cyc();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
